spi_reg_arbiter: RTL and testbench

- Owns an 8 x 8-bit register bank and shares its single access port between two requesters: the SPI command stream and a local host port.
- The SPI stream arrives as bytes from the SPI deserialiser and is decoded into single or auto-incrementing burst read/write operations.
- Read data for the SPI side is handed back for shifting out on MISO.
- A third, combinational debug read port feeds the 7-segment/debug nibble mux.

---
 rtl/spi_reg_arbiter_if.sv | 42 ++++
 rtl/spi_reg_arbiter.sv | 152 +++++++++++++++
 tb/tb_spi_reg_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_arbiter_if.sv
// Bus bundle for spi_reg_arbiter: SPI byte stream, host access port,
// debug read port and the overrun flag. The arbiter uses the slave side.
interface spi_reg_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              spi_cs_n;
    logic              spi_rx_valid;
    logic [DATA_W-1:0] spi_rx_byte;
    logic              spi_tx_load;
    logic [DATA_W-1:0] spi_tx_byte;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic [ADDR_W-1:0] debug_addr;
    logic [DATA_W-1:0] debug_byte;
    logic              overrun;

    modport slave (
        input  spi_cs_n, spi_rx_valid, spi_rx_byte,
        input  host_req, host_we, host_addr, host_wdata,
        input  debug_addr,
        output spi_tx_load, spi_tx_byte,
        output host_gnt, host_rvalid, host_rdata,
        output debug_byte, overrun
    );

    modport master (
        output spi_cs_n, spi_rx_valid, spi_rx_byte,
        output host_req, host_we, host_addr, host_wdata,
        output debug_addr,
        input  spi_tx_load, spi_tx_byte,
        input  host_gnt, host_rvalid, host_rdata,
        input  debug_byte, overrun
    );
endinterface

// File: rtl/spi_reg_arbiter.sv
// Register bank shared between an SPI command decoder and a host port.
// SPI ops go through a one-entry pending buffer; ties between the pending
// SPI op and the host alternate based on who won last.
module spi_reg_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    spi_reg_arbiter_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_RDATA} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr, addr_nx;

    logic              post, post_we;
    logic [ADDR_W-1:0] post_addr;

    logic              pend_vld, pend_we;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;

    logic [DATA_W-1:0] bank [NUM_REGS];
    logic              last_spi;   // 0 = host won last, so SPI takes the next tie
    logic              spi_win, host_win;
    logic              rx_take, rx_ok;

    logic              tx_load, rvalid, ovr;
    logic [DATA_W-1:0] tx_byte, rdata;

    // A byte only counts inside a frame; it is dropped if the buffer is still full
    assign rx_take = bus.spi_rx_valid && !bus.spi_cs_n;
    assign rx_ok   = rx_take && !pend_vld;

    // SPI decoder next-state: command byte, then write data or dummy read bytes
    always_comb begin
        state_nx  = state;
        addr_nx   = addr;
        post      = 1'b0;
        post_we   = 1'b0;
        post_addr = addr;
        if (bus.spi_cs_n) begin
            state_nx = S_IDLE;
        end else if (rx_ok) begin
            case (state)
                S_IDLE: begin
                    addr_nx = bus.spi_rx_byte[ADDR_W-1:0];
                    if (bus.spi_rx_byte[DATA_W-1]) begin
                        state_nx = S_WDATA;
                    end else begin
                        post      = 1'b1;
                        post_addr = bus.spi_rx_byte[ADDR_W-1:0];
                        state_nx  = S_RDATA;
                    end
                end
                S_WDATA: begin
                    post      = 1'b1;
                    post_we   = 1'b1;
                    post_addr = addr;
                    addr_nx   = addr + 1'b1;
                end
                S_RDATA: begin
                    post      = 1'b1;
                    post_addr = addr + 1'b1;
                    addr_nx   = addr + 1'b1;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // SPI decoder state and burst address
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            addr  <= '0;
        end else begin
            state <= state_nx;
            addr  <= addr_nx;
        end
    end

    // One-entry pending buffer; a post and a grant can never coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld  <= 1'b0;
            pend_we   <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else if (post) begin
            pend_vld  <= 1'b1;
            pend_we   <= post_we;
            pend_addr <= post_addr;
            pend_data <= bus.spi_rx_byte;
        end else if (spi_win) begin
            pend_vld  <= 1'b0;
        end
    end

    // Sticky overrun: set whenever an in-frame byte finds the buffer full
    always_ff @(posedge clk) begin
        if (rst)                      ovr <= 1'b0;
        else if (rx_take && pend_vld) ovr <= 1'b1;
    end

    // Round-robin on ties, otherwise whoever is asking
    assign spi_win  = pend_vld && (!bus.host_req || !last_spi);
    assign host_win = bus.host_req && !spi_win;

    // Single bank access per cycle: winner writes or captures read data
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
            last_spi <= 1'b0;
            tx_load  <= 1'b0;
            tx_byte  <= '0;
            rvalid   <= 1'b0;
            rdata    <= '0;
        end else begin
            tx_load <= 1'b0;
            rvalid  <= 1'b0;
            if (spi_win) begin
                last_spi <= 1'b1;
                if (pend_we) begin
                    bank[pend_addr] <= pend_data;
                end else begin
                    tx_byte <= bank[pend_addr];
                    tx_load <= 1'b1;
                end
            end else if (host_win) begin
                last_spi <= 1'b0;
                if (bus.host_we) begin
                    bank[bus.host_addr] <= bus.host_wdata;
                end else begin
                    rdata  <= bank[bus.host_addr];
                    rvalid <= 1'b1;
                end
            end
        end
    end

    assign bus.host_gnt    = host_win;
    assign bus.host_rvalid = rvalid;
    assign bus.host_rdata  = rdata;
    assign bus.spi_tx_load = tx_load;
    assign bus.spi_tx_byte = tx_byte;
    assign bus.overrun     = ovr;
    assign bus.debug_byte  = bank[bus.debug_addr];
endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Directed bench for spi_reg_arbiter: inputs change 1 time unit after the
// rising edge, outputs are checked at the falling edge or via the debug port.
module tb_spi_reg_arbiter;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    spi_reg_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    spi_reg_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // One SPI byte followed by an idle cycle in which the posted op is granted
    task automatic spi_byte(input logic [7:0] b);
        bus.spi_rx_valid = 1'b1;
        bus.spi_rx_byte  = b;
        tick();
        bus.spi_rx_valid = 1'b0;
        tick();
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] a, input logic [7:0] e);
        bus.debug_addr = a;
        #1;
        check(tag, bus.debug_byte, e);
    endtask

    // Uncontended host write, granted in the request cycle
    task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = a;
        bus.host_wdata = d;
        neg();
        check("host_wr_gnt", 8'(bus.host_gnt), 8'h01);
        tick();
        bus.host_req = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.spi_cs_n     = 1'b1;
        bus.spi_rx_valid = 1'b0;
        bus.spi_rx_byte  = '0;
        bus.host_req     = 1'b0;
        bus.host_we      = 1'b0;
        bus.host_addr    = '0;
        bus.host_wdata   = '0;
        bus.debug_addr   = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        neg();
        check("rst_tx_load", 8'(bus.spi_tx_load), 8'h00);
        check("rst_tx_byte", bus.spi_tx_byte, 8'h00);
        check("rst_gnt", 8'(bus.host_gnt), 8'h00);
        check("rst_rvalid", 8'(bus.host_rvalid), 8'h00);
        check("rst_rdata", bus.host_rdata, 8'h00);
        check("rst_overrun", 8'(bus.overrun), 8'h00);
        chk_reg("rst_bank7", 3'd7, 8'h00);
        tick();

        // Contention right after reset: SPI wins first tie
        bus.spi_cs_n = 1'b0;
        spi_byte(8'h81);
        bus.spi_rx_valid = 1'b1;
        bus.spi_rx_byte  = 8'h55;
        tick();
        bus.spi_rx_valid = 1'b0;
        bus.host_req     = 1'b1;
        bus.host_we      = 1'b1;
        bus.host_addr    = 3'd1;
        bus.host_wdata   = 8'h66;
        neg();
        check("tie1_spi_first", 8'(bus.host_gnt), 8'h00);
        tick();
        neg();
        check("tie1_host_next", 8'(bus.host_gnt), 8'h01);
        chk_reg("tie1_spi_wrote", 3'd1, 8'h55);
        tick();
        bus.host_req = 1'b0;
        chk_reg("tie1_final", 3'd1, 8'h66);

        // SPI alone, then a repeat tie goes to host first
        spi_byte(8'h77);
        chk_reg("burst_addr2", 3'd2, 8'h77);
        bus.spi_rx_valid = 1'b1;
        bus.spi_rx_byte  = 8'h88;
        tick();
        bus.spi_rx_valid = 1'b0;
        bus.host_req     = 1'b1;
        bus.host_addr    = 3'd3;
        bus.host_wdata   = 8'h99;
        neg();
        check("tie2_host_first", 8'(bus.host_gnt), 8'h01);
        tick();
        bus.host_req = 1'b0;
        neg();
        check("tie2_spi_next", 8'(bus.host_gnt), 8'h00);
        chk_reg("tie2_host_wrote", 3'd3, 8'h99);
        tick();
        chk_reg("tie2_final", 3'd3, 8'h88);
        bus.spi_cs_n = 1'b1;
        tick();

        // SPI write burst with wrap
        bus.spi_cs_n = 1'b0;
        spi_byte(8'h86);
        spi_byte(8'hAA);
        spi_byte(8'hBB);
        spi_byte(8'hCC);
        bus.spi_cs_n = 1'b1;
        tick();
        chk_reg("wr_bank6", 3'd6, 8'hAA);
        chk_reg("wr_bank7", 3'd7, 8'hBB);
        chk_reg("wr_bank0_wrap", 3'd0, 8'hCC);
        check("wr_overrun", 8'(bus.overrun), 8'h00);

        // Host read-after-write
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 3'd5;
        bus.host_wdata = 8'h3C;
        neg();
        check("raw_wr_gnt", 8'(bus.host_gnt), 8'h01);
        tick();
        bus.host_we = 1'b0;
        neg();
        check("raw_rd_gnt", 8'(bus.host_gnt), 8'h01);
        check("raw_no_early_rvalid", 8'(bus.host_rvalid), 8'h00);
        tick();
        bus.host_req = 1'b0;
        neg();
        check("raw_rvalid", 8'(bus.host_rvalid), 8'h01);
        check("raw_rdata", bus.host_rdata, 8'h3C);
        tick();
        neg();
        check("raw_rvalid_pulse", 8'(bus.host_rvalid), 8'h00);
        tick();

        // SPI read burst
        host_wr(3'd2, 8'h11);
        host_wr(3'd3, 8'h22);
        bus.spi_cs_n = 1'b0;
        spi_byte(8'h02);
        neg();
        check("rd0_load", 8'(bus.spi_tx_load), 8'h01);
        check("rd0_byte", bus.spi_tx_byte, 8'h11);
        spi_byte(8'h00);
        neg();
        check("rd1_load", 8'(bus.spi_tx_load), 8'h01);
        check("rd1_byte", bus.spi_tx_byte, 8'h22);
        spi_byte(8'h00);
        neg();
        check("rd2_load", 8'(bus.spi_tx_load), 8'h01);
        check("rd2_byte", bus.spi_tx_byte, 8'h00);
        tick();
        neg();
        check("rd_load_pulse", 8'(bus.spi_tx_load), 8'h00);
        bus.spi_cs_n = 1'b1;
        tick();

        // Overrun: host wins the tie, second byte arrives while buffer full
        bus.spi_cs_n = 1'b0;
        spi_byte(8'h80);
        spi_byte(8'h01);
        bus.spi_rx_valid = 1'b1;
        bus.spi_rx_byte  = 8'h02;
        tick();
        bus.spi_rx_byte  = 8'h03;
        bus.host_req     = 1'b1;
        bus.host_we      = 1'b1;
        bus.host_addr    = 3'd3;
        bus.host_wdata   = 8'h44;
        neg();
        check("ovr_host_wins_tie", 8'(bus.host_gnt), 8'h01);
        tick();
        bus.spi_rx_valid = 1'b0;
        neg();
        check("ovr_flag", 8'(bus.overrun), 8'h01);
        check("ovr_spi_turn", 8'(bus.host_gnt), 8'h00);
        tick();
        neg();
        check("ovr_host_again", 8'(bus.host_gnt), 8'h01);
        tick();
        bus.host_req = 1'b0;
        spi_byte(8'h04);
        bus.spi_cs_n = 1'b1;
        tick();
        chk_reg("ovr_bank0", 3'd0, 8'h01);
        chk_reg("ovr_bank1", 3'd1, 8'h02);
        chk_reg("ovr_bank2", 3'd2, 8'h04);
        chk_reg("ovr_bank3", 3'd3, 8'h44);
        check("ovr_sticky", 8'(bus.overrun), 8'h01);

        // Abort after write command: next frame decodes a fresh command
        bus.spi_cs_n = 1'b0;
        spi_byte(8'h83);
        bus.spi_cs_n = 1'b1;
        tick();
        bus.spi_cs_n = 1'b0;
        spi_byte(8'h05);
        neg();
        check("abort_rd_load", 8'(bus.spi_tx_load), 8'h01);
        check("abort_rd_byte", bus.spi_tx_byte, 8'h3C);
        bus.spi_cs_n = 1'b1;
        tick();
        chk_reg("abort_bank3", 3'd3, 8'h44);

        // Reset mid-burst with an op pending
        bus.spi_cs_n = 1'b0;
        spi_byte(8'h84);
        bus.spi_rx_valid = 1'b1;
        bus.spi_rx_byte  = 8'hEE;
        tick();
        bus.spi_rx_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.spi_cs_n = 1'b1;
        neg();
        check("rst2_overrun", 8'(bus.overrun), 8'h00);
        check("rst2_tx_byte", bus.spi_tx_byte, 8'h00);
        check("rst2_rdata", bus.host_rdata, 8'h00);
        check("rst2_tx_load", 8'(bus.spi_tx_load), 8'h00);
        for (int i = 0; i < 8; i++) chk_reg("rst2_bank", 3'(i), 8'h00);
        tick();
        tick();
        chk_reg("rst2_pend_dropped", 3'd4, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
